// File: rtl/sd_cmd_rx_if.sv
// SD command-line receive bundle: bit strobe, serial data and arm request in;
// status pulses and decoded frame fields out.
// Latency and backpressure are properties of the receiver; this bundle only groups the wires.
interface sd_cmd_rx_if;
    logic        bit_en;     // one-clk strobe, cmd_in sampled on this cycle
    logic        cmd_in;     // serial CMD line, MSB first
    logic        arm;        // one-clk request to start looking for a frame
    logic        busy;       // receiver not idle
    logic        done;       // one-clk pulse, result fields valid
    logic        timeout;    // one-clk pulse, start-bit wait expired
    logic        dir_bit;    // frame bit 1
    logic [5:0]  cmd_index;  // frame bits 2..7
    logic [31:0] cmd_arg;    // frame bits 8..39
    logic        crc_ok;     // received CRC7 matches computed CRC7
    logic        end_ok;     // end bit was 1

    modport master (
        output bit_en, cmd_in, arm,
        input  busy, done, timeout, dir_bit, cmd_index, cmd_arg, crc_ok, end_ok
    );

    modport slave (
        input  bit_en, cmd_in, arm,
        output busy, done, timeout, dir_bit, cmd_index, cmd_arg, crc_ok, end_ok
    );
endinterface

// File: rtl/sd_cmd_rx.sv
// SD command frame receiver: 48-bit frame, CRC7 check, start-bit timeout.
// Latency: done/timeout pulse one clk after the edge that samples the final/TIMEOUT-th strobe.
// Backpressure: none; the line is paced by bit_en strobes, gaps of any length are legal.
// Ports: clk, rst (sync, active-high); bus (slave modport of sd_cmd_rx_if).
module sd_cmd_rx #(
    parameter int unsigned TIMEOUT = 64
) (
    input logic        clk,
    input logic        rst,
    sd_cmd_rx_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT_START, SHIFT, DONE} state_t;

    state_t      state_q;
    logic [9:0]  to_cnt_q;
    logic [5:0]  bit_cnt_q;
    logic [6:0]  crc_q;
    logic [6:0]  crc_d;
    logic [6:0]  rx_crc_q;
    logic [38:0] sh_q;        // frame bits 1..39 (dir, index, arg)
    logic        busy_q;
    logic        done_q;
    logic        timeout_q;
    logic        dir_q;
    logic [5:0]  idx_q;
    logic [31:0] arg_q;
    logic        crc_ok_q;
    logic        end_ok_q;

    // CRC7, x^7 + x^3 + 1, one bit per step.
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic g;
        g = b ^ c[6];
        return {c[5], c[4], c[3], c[2] ^ g, c[1], c[0], g};
    endfunction

    assign crc_d = crc7_step(crc_q, bus.cmd_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            to_cnt_q  <= '0;
            bit_cnt_q <= '0;
            crc_q     <= '0;
            rx_crc_q  <= '0;
            sh_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            dir_q     <= 1'b0;
            idx_q     <= '0;
            arg_q     <= '0;
            crc_ok_q  <= 1'b0;
            end_ok_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // bit_en in the arming cycle is deliberately not looked at.
                    if (bus.arm) begin
                        state_q  <= WAIT_START;
                        busy_q   <= 1'b1;
                        to_cnt_q <= '0;
                    end
                end
                WAIT_START: begin
                    if (bus.bit_en) begin
                        if (!bus.cmd_in) begin
                            // Start bit is frame bit 0; it seeds the CRC from zero.
                            state_q   <= SHIFT;
                            bit_cnt_q <= 6'd1;
                            crc_q     <= crc7_step(7'h00, bus.cmd_in);
                            to_cnt_q  <= '0;
                        end else if (to_cnt_q == 10'(TIMEOUT - 1)) begin
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                            to_cnt_q  <= '0;
                        end else begin
                            to_cnt_q <= to_cnt_q + 10'd1;
                        end
                    end
                end
                SHIFT: begin
                    if (bus.bit_en) begin
                        bit_cnt_q <= bit_cnt_q + 6'd1;
                        if (bit_cnt_q <= 6'd39) begin
                            crc_q <= crc_d;
                            sh_q  <= {sh_q[37:0], bus.cmd_in};
                        end else if (bit_cnt_q <= 6'd46) begin
                            rx_crc_q <= {rx_crc_q[5:0], bus.cmd_in};
                        end else begin
                            // Bit 47: publish the whole frame at once so results
                            // stay stable throughout the next reception.
                            state_q   <= DONE;
                            bit_cnt_q <= '0;
                            done_q    <= 1'b1;
                            end_ok_q  <= bus.cmd_in;
                            crc_ok_q  <= (rx_crc_q == crc_q);
                            dir_q     <= sh_q[38];
                            idx_q     <= sh_q[37:32];
                            arg_q     <= sh_q[31:0];
                        end
                    end
                end
                DONE: begin
                    // arm is ignored here; always return to IDLE.
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.timeout   = timeout_q;
    assign bus.dir_bit   = dir_q;
    assign bus.cmd_index = idx_q;
    assign bus.cmd_arg   = arg_q;
    assign bus.crc_ok    = crc_ok_q;
    assign bus.end_ok    = end_ok_q;

endmodule

// File: tb/tb_sd_cmd_rx.sv
// Testbench for sd_cmd_rx: directed SD command frames plus randomized frames,
// with a scoreboard of expected done/timeout events checked by a monitor.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_sd_cmd_rx;

    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    bit   started = 1'b0;

    typedef struct {
        bit        is_to;
        bit        dir;
        bit [5:0]  idx;
        bit [31:0] arg;
        bit        crc_ok;
        bit        end_ok;
        int        cyc;
    } exp_t;

    exp_t sb[$];

    // Result fields the outputs must currently hold.
    bit        h_dir = 1'b0;
    bit [5:0]  h_idx = '0;
    bit [31:0] h_arg = '0;
    bit        h_crc = 1'b0;
    bit        h_end = 1'b0;

    sd_cmd_rx_if bus ();

    sd_cmd_rx #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            h_dir <= 1'b0;
            h_idx <= '0;
            h_arg <= '0;
            h_crc <= 1'b0;
            h_end <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference CRC7 by polynomial long division of msg * x^7 by 0x89.
    function automatic logic [6:0] ref_crc(input logic [39:0] m);
        logic [46:0] v;
        v = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
        return v[6:0];
    endfunction

    function automatic exp_t frame_exp(input logic [47:0] f, input int c);
        exp_t e;
        e.is_to  = 1'b0;
        e.dir    = f[46];
        e.idx    = f[45:40];
        e.arg    = f[39:8];
        e.crc_ok = (f[7:1] == ref_crc(f[47:8]));
        e.end_ok = f[0];
        e.cyc    = c;
        return e;
    endfunction

    // Monitor: every done/timeout must match the head of the scoreboard;
    // otherwise the result fields must hold their last published values.
    always @(negedge clk) begin
        exp_t e;
        if (started && !rst) begin
            if (bus.done && bus.timeout)
                chk("done_and_timeout", 1, 0);
            if (bus.done || bus.timeout) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", {bus.done, bus.timeout}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind_timeout", bus.timeout, e.is_to);
                    chk("event_cycle", cyc, e.cyc);
                    if (!e.is_to) begin
                        chk("busy_in_done", bus.busy, 1);
                        chk("dir_bit", bus.dir_bit, e.dir);
                        chk("cmd_index", bus.cmd_index, e.idx);
                        chk("cmd_arg", bus.cmd_arg, e.arg);
                        chk("crc_ok", bus.crc_ok, e.crc_ok);
                        chk("end_ok", bus.end_ok, e.end_ok);
                        h_dir = e.dir;
                        h_idx = e.idx;
                        h_arg = e.arg;
                        h_crc = e.crc_ok;
                        h_end = e.end_ok;
                    end else begin
                        chk("busy_after_timeout", bus.busy, 0);
                    end
                end
            end else begin
                chk("result_hold", {bus.dir_bit, bus.cmd_index, bus.cmd_arg, bus.crc_ok, bus.end_ok},
                    {h_dir, h_idx, h_arg, h_crc, h_end});
            end
        end
    end

    task automatic step(input bit be, input bit ci, input bit ar);
        @(posedge clk);
        #1;
        bus.bit_en = be;
        bus.cmd_in = ci;
        bus.arm    = ar;
    endtask

    task automatic gaps(input int gmin, input int gmax, input bit junk_arm);
        int n;
        n = $urandom_range(gmax, gmin);
        for (int g = 0; g < n; g++)
            step(1'b0, 1'($urandom), junk_arm & ($urandom_range(0, 3) == 0));
    endtask

    // Arm and send one frame. abort_at >= 0 asserts rst (with arm and bit_en)
    // in place of that frame bit, abandoning the frame.
    task automatic send_frame(input logic [47:0] f, input int gmin, input int gmax,
                              input bit en_with_arm, input int pre_ones, input int abort_at);
        step(en_with_arm, 1'b0, 1'b1);
        for (int p = 0; p < pre_ones; p++) begin
            gaps(gmin, gmax, 1'b1);
            step(1'b1, 1'b1, 1'b0);
        end
        for (int k = 0; k < 48; k++) begin
            gaps(gmin, gmax, 1'b1);
            if (k == abort_at) begin
                step(1'b1, 1'b0, 1'b1);
                rst = 1'b1;
                step(1'b0, 1'b1, 1'b0);
                rst = 1'b0;
                @(negedge clk);
                chk("busy_after_abort", bus.busy, 0);
                return;
            end
            step(1'b1, f[47-k], (k > 0) && ($urandom_range(0, 7) == 0));
            if (k == 47) sb.push_back(frame_exp(f, cyc + 1));
        end
        step(1'b0, 1'b1, 1'b1);   // DONE cycle: this arm must be ignored
        step(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("busy_idle_after_done", bus.busy, 0);
    endtask

    task automatic timeout_run();
        exp_t e;
        step(1'b0, 1'b1, 1'b1);
        for (int n = 1; n <= TO; n++) begin
            gaps(0, 2, 1'b1);
            step(1'b1, 1'b1, 1'b0);
            if (n == TO) begin
                e = '{is_to: 1'b1, dir: 1'b0, idx: 6'h0, arg: 32'h0,
                      crc_ok: 1'b0, end_ok: 1'b0, cyc: cyc + 1};
                sb.push_back(e);
            end
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("busy_low_after_timeout", bus.busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] f;
        logic [39:0] m;
        logic [6:0]  c;
        bus.bit_en = 1'b0;
        bus.cmd_in = 1'b1;
        bus.arm    = 1'b0;
        rst        = 1'b1;
        repeat (3) step(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_timeout", bus.timeout, 0);
        chk("rst_fields", {bus.dir_bit, bus.cmd_index, bus.cmd_arg, bus.crc_ok, bus.end_ok}, 0);
        rst = 1'b0;
        started = 1'b1;

        send_frame(48'h40_00_00_00_00_95, 3, 3, 1'b0, 0, -1);   // CMD0, one strobe per 4 clks
        send_frame(48'h48_00_00_01_AA_87, 0, 0, 1'b0, 0, -1);   // CMD8, back-to-back
        send_frame(48'h48_00_00_01_AB_87, 0, 1, 1'b1, 2, -1);   // CMD8, arg flipped
        send_frame(48'h77_00_00_00_00_64, 0, 2, 1'b1, 0, -1);   // CMD55, end bit 0
        timeout_run();
        send_frame(48'h40_00_00_00_00_95, 0, 1, 1'b0, 0, 20);   // aborted by reset
        send_frame(48'h40_00_00_00_00_95, 1, 2, 1'b0, 1, -1);   // CMD0 afterwards

        for (int r = 0; r < 20; r++) begin
            m = {1'b0, 1'($urandom), 6'($urandom), 32'($urandom)};
            c = ref_crc(m);
            if ($urandom_range(0, 3) == 0) c = c ^ 7'(1 << $urandom_range(0, 6));
            f = {m, c, 1'($urandom_range(0, 4) != 0)};
            send_frame(f, 0, 3, 1'($urandom), $urandom_range(0, 3), -1);
        end

        repeat (10) step(1'b0, 1'b1, 1'b0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
